fir_inverse_filter: RTL
=======================

FIR_INVERSE_FILTER -- requirements
Module: fir_inverse_filter

Interface
REQ-001 Parameter WL, default 4: width of the recovered signed sample x.
REQ-002 Parameter WL_C, default 4: width of the signed coefficients h1 and h2; h0 is fixed at 1 (monic filter).
REQ-003 Parameter WL_Y, default 10: width of the signed filtered input sample y.
REQ-004 CLK  in  1: single clock; all state changes on its rising edge.
REQ-005 RST_n  in  1: asynchronous, active-low reset.
REQ-006 coef_load  in  1: when high, captures coef_h1 and coef_h2 and clears history.
REQ-007 coef_h1, coef_h2  in  WL_C each: signed feedback coefficients.
REQ-008 clear  in  1: when high, clears history and keeps coefficients.
REQ-009 y_valid  in  1, y  in  WL_Y, y_ready  out  1: input handshake; transfer occurs when y_valid and y_ready are both high.
REQ-010 x_valid  out  1, x  out  WL, x_ready  in  1: output handshake; transfer occurs when x_valid and x_ready are both high.
REQ-011 x_sat  out  1: high alongside x when the current x was saturated.
REQ-012 sat_count  out  8: count of saturated outputs, saturating at 255.

Function
REQ-013 Recovery equation: x[n] = sat_WL(y[n] - h1*x[n-1] - h2*x[n-2]), using the saturated past outputs as history.
REQ-014 Products: WL_C+WL bits, signed.
REQ-015 Accumulator: WL_Y+2 bits, signed; no intermediate overflow is permitted.
REQ-016 Saturation: clamp to [-2^(WL-1), 2^(WL-1)-1] and set x_sat for that sample.
REQ-017 FSM states: UNCFG and RUN.
REQ-018 UNCFG -> RUN on coef_load; RUN -> RUN on coef_load (reload). No other transitions exist except reset, which goes to UNCFG.
REQ-019 In UNCFG, y_ready is 0.
REQ-020 In RUN, y_ready = !x_valid || x_ready, unless coef_load or clear is high that cycle, in which case y_ready is 0.
REQ-021 Latency: an accepted y produces x_valid=1 with the corresponding x on the next cycle (1 cycle); throughput is 1 sample per cycle.
REQ-022 History shifts (x[n-2] <- x[n-1], x[n-1] <- new x) only on an input transfer.
REQ-023 With x_valid=1 and x_ready=0, x, x_sat and x_valid hold stable and no input is accepted.
REQ-024 x_valid falls after an output transfer if no new input transfer occurs in the same cycle.
REQ-025 coef_load or clear: zero both history registers and deassert x_valid on the next cycle; a pending output is discarded.
REQ-026 If coef_load and clear are both high, coef_load takes precedence (coefficients update and history clears).
REQ-027 sat_count increments by 1 on each input transfer whose result saturates; it is cleared only by reset.

Reset
REQ-028 On RST_n low, immediately and asynchronously: state=UNCFG, h1=h2=0, history=0, x=0, x_valid=0, x_sat=0, sat_count=0, y_ready=0.
REQ-029 Reset asserted mid-stream discards any in-flight sample; after reset releases, a new coef_load is required before any input is accepted.

Structure
REQ-030 A shared package holds the FSM state encoding, the saturation bounds derived from WL, and the SAT_COUNT_MAX=255 constant.
REQ-031 One sub-module, sat_clamp, performs the parameterized signed saturation of the WL_Y+2-bit accumulator to WL bits and produces the sat flag.

Verification
REQ-032 Recovery: load h1=2, h2=1; feed y=-1,-4,-2 with x_ready=1 -> x=-1,-2,3, each one cycle after its input; x_sat=0 throughout.
REQ-033 Saturation: load h1=0, h2=0; feed y=100, then y=-100 -> x=7 with x_sat=1, then x=-8 with x_sat=1; sat_count=2.
REQ-034 Backpressure: with x_valid=1, hold x_ready=0 for 3 cycles -> x is stable and y_ready=0 for those cycles; raising x_ready transfers the held x and accepts the next y in the same cycle.
REQ-035 Reload: after streaming with nonzero history, pulse coef_load with h1=1, h2=0, then feed y=5 -> x=5, showing the history was cleared.
REQ-036 Unconfigured: after reset, drive y_valid=1 for 4 cycles -> y_ready=0 and x_valid=0 throughout.
REQ-037 Mid-stream reset: pull RST_n low while x_valid=1 -> all outputs go to 0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/fir_inverse_filter_pkg.sv
// Shared definitions for the inverse FIR filter: FSM encoding,
// saturation bounds and the saturated-output counter limit.
package fir_inverse_filter_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int SAT_COUNT_MAX = 255;

  // Largest value representable in a signed word of width wl.
  function automatic int sat_hi(input int wl);
    return (1 << (wl - 1)) - 1;
  endfunction

  // Smallest value representable in a signed word of width wl.
  function automatic int sat_lo(input int wl);
    return -(1 << (wl - 1));
  endfunction

endpackage

// File: rtl/fir_inverse_filter_sat_clamp.sv
// Signed saturation of a wide accumulator down to the output sample width,
// with a flag raised whenever clamping took place.
module sat_clamp
  import fir_inverse_filter_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 4
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] sat_out,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0]  HI_W = IN_W'(sat_hi(OUT_W));
  localparam logic signed [IN_W-1:0]  LO_W = IN_W'(sat_lo(OUT_W));
  localparam logic signed [OUT_W-1:0] HI_N = OUT_W'(sat_hi(OUT_W));
  localparam logic signed [OUT_W-1:0] LO_N = OUT_W'(sat_lo(OUT_W));

  // Clamp to the output range; in-range values pass through by truncation.
  always_comb begin
    sat_out = acc[OUT_W-1:0];
    sat     = 1'b0;
    if (acc > HI_W) begin
      sat_out = HI_N;
      sat     = 1'b1;
    end else if (acc < LO_W) begin
      sat_out = LO_N;
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/fir_inverse_filter.sv
// Inverse of a monic 3-tap FIR: recovers x[n] = y[n] - h1*x[n-1] - h2*x[n-2]
// with saturated feedback, valid/ready handshakes and a saturation counter.
module fir_inverse_filter
  import fir_inverse_filter_pkg::*;
#(
  parameter int WL   = 4,
  parameter int WL_C = 4,
  parameter int WL_Y = 10
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   coef_load,
  input  logic signed [WL_C-1:0] coef_h1,
  input  logic signed [WL_C-1:0] coef_h2,
  input  logic                   clear,
  input  logic                   y_valid,
  input  logic signed [WL_Y-1:0] y,
  output logic                   y_ready,
  output logic                   x_valid,
  output logic signed [WL-1:0]   x,
  input  logic                   x_ready,
  output logic                   x_sat,
  output logic [7:0]             sat_count
);

  localparam int PROD_W = WL_C + WL;
  localparam int ACC_W  = WL_Y + 2;
  localparam logic [7:0] CNT_MAX = 8'(SAT_COUNT_MAX);

  state_t state, next_state;

  logic signed [WL_C-1:0]   h1, h2;
  logic signed [WL-1:0]     hist1_p1, hist2_p1;
  logic signed [PROD_W-1:0] prod1_p0, prod2_p0;
  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [WL-1:0]     x_p0;
  logic                     sat_p0;
  logic                     in_xfer, out_xfer;

  assign y_ready  = (state == RUN) && !coef_load && !clear && (!x_valid || x_ready);
  assign in_xfer  = y_valid && y_ready;
  assign out_xfer = x_valid && x_ready;

  // ---- stage 0: feedback products, accumulate, saturate ----
  always_comb begin
    prod1_p0 = h1 * hist1_p1;
    prod2_p0 = h2 * hist2_p1;
    acc_p0   = ACC_W'(y) - ACC_W'(prod1_p0) - ACC_W'(prod2_p0);
  end

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (WL)
  ) u_sat_clamp (
    .acc     (acc_p0),
    .sat_out (x_p0),
    .sat     (sat_p0)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= UNCFG;
    else        state <= next_state;
  end

  // Next state: only a coefficient load leaves (or re-enters) RUN.
  always_comb begin
    next_state = state;
    if (coef_load) next_state = RUN;
  end

  // ---- stage 1: coefficients, history, output register and counter ----
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      h1        <= '0;
      h2        <= '0;
      hist1_p1  <= '0;
      hist2_p1  <= '0;
      x         <= '0;
      x_valid   <= 1'b0;
      x_sat     <= 1'b0;
      sat_count <= '0;
    end else if (coef_load) begin
      h1       <= coef_h1;
      h2       <= coef_h2;
      hist1_p1 <= '0;
      hist2_p1 <= '0;
      x_valid  <= 1'b0;
    end else if (clear) begin
      hist1_p1 <= '0;
      hist2_p1 <= '0;
      x_valid  <= 1'b0;
    end else if (in_xfer) begin
      x        <= x_p0;
      x_sat    <= sat_p0;
      x_valid  <= 1'b1;
      hist2_p1 <= hist1_p1;
      hist1_p1 <= x_p0;
      if (sat_p0 && sat_count != CNT_MAX) sat_count <= sat_count + 8'd1;
    end else if (out_xfer) begin
      x_valid <= 1'b0;
    end
  end

endmodule
